// File: rtl/scr1_dap_chain_ctrl.sv
// SysCLK-side DAP scan-chain controller: owns the chain shift register,
// drives TDO and sequences debug register reads/writes over req/ack.
module scr1_dap_chain_ctrl #(
  parameter int DATA_W  = 32,
  parameter int CH_ID_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dap_ch_sel_core,
  input  logic [CH_ID_W-1:0] dap_ch_id_core,
  input  logic               dap_ch_capture_core,
  input  logic               dap_ch_shift_core,
  input  logic               dap_ch_update_core,
  input  logic               dap_ch_tdi_core,
  output logic               dap_ch_tdo_core,
  output logic               reg_req,
  output logic               reg_we,
  output logic [CH_ID_W-1:0] reg_addr,
  output logic [DATA_W-1:0]  reg_wdata,
  input  logic               reg_ack,
  input  logic [DATA_W-1:0]  reg_rdata,
  input  logic               reg_err,
  output logic               busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RD = 2'b01, ST_WR = 2'b10} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W+1:0]   r_sr, w_sr_nxt;     // [0]=busy, [1]=sticky err, [DATA_W+1:2]=data
  logic                r_err, w_err_nxt;
  logic                r_ovr, w_ovr_nxt;   // shift seen during the current read
  logic                r_req, w_req_nxt;
  logic                r_we, w_we_nxt;
  logic [CH_ID_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                w_cap, w_upd, w_shf, w_ack;

  // Strobe gating and priority: capture > update > shift, all masked when deselected.
  assign w_cap = dap_ch_sel_core & dap_ch_capture_core;
  assign w_upd = dap_ch_sel_core & dap_ch_update_core & ~dap_ch_capture_core;
  assign w_shf = dap_ch_sel_core & dap_ch_shift_core & ~dap_ch_capture_core & ~dap_ch_update_core;
  assign w_ack = reg_ack & r_req;

  // Next-state logic; strobes are judged against the pre-ack state.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_err_nxt   = r_err;
    w_ovr_nxt   = r_ovr;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_cap) begin
          w_sr_nxt    = {{DATA_W{1'b0}}, r_err, 1'b1};
          w_addr_nxt  = dap_ch_id_core;
          w_we_nxt    = 1'b0;
          w_ovr_nxt   = 1'b0;
          w_state_nxt = ST_RD;
        end else if (w_upd) begin
          if (r_sr[1]) begin
            w_err_nxt = 1'b0;            // clear command
          end else begin
            w_wdata_nxt = r_sr[DATA_W+1:2];
            w_addr_nxt  = dap_ch_id_core;
            w_we_nxt    = 1'b1;
            w_state_nxt = ST_WR;
          end
        end else if (w_shf) begin
          w_sr_nxt = {dap_ch_tdi_core, r_sr[DATA_W+1:1]};
        end
      end
      default: begin
        if (w_ack) begin
          w_state_nxt = ST_IDLE;
          if (r_state == ST_RD) begin
            // A shift in the ack cycle also counts as an overrun.
            if (!r_ovr && !w_shf)
              w_sr_nxt = {reg_rdata, r_err | reg_err, 1'b0};
            w_err_nxt = r_err | reg_err | r_ovr | w_shf;
          end else begin
            w_err_nxt = r_err | reg_err;
          end
        end
        if (w_cap) begin
          w_sr_nxt = {{DATA_W{1'b0}}, r_err, 1'b1};
        end else if (w_upd) begin
          w_err_nxt = 1'b1;              // update collided with a busy transaction
        end else if (w_shf) begin
          w_sr_nxt = {dap_ch_tdi_core, r_sr[DATA_W+1:1]};
          if (r_state == ST_RD) w_ovr_nxt = 1'b1;
        end
      end
    endcase
    w_req_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_err   <= w_err_nxt;
      r_ovr   <= w_ovr_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign dap_ch_tdo_core = dap_ch_sel_core & r_sr[0];
  assign reg_req         = r_req;
  assign reg_we          = r_we;
  assign reg_addr        = r_addr;
  assign reg_wdata       = r_wdata;
  assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_scr1_dap_chain_ctrl.sv
// Bench for scr1_dap_chain_ctrl: vector table, directed corner sequences and
// random traffic, all checked against a transaction-level model every cycle.
module tb_scr1_dap_chain_ctrl;

  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic [IW-1:0] id = '0;
  logic          tdo, req, we, ack = 1'b0, rerr = 1'b0, bsy;
  logic [IW-1:0] addr;
  logic [DW-1:0] wdata, rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scr1_dap_chain_ctrl #(.DATA_W(DW), .CH_ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dap_ch_sel_core(sel), .dap_ch_id_core(id),
    .dap_ch_capture_core(cap), .dap_ch_shift_core(shf), .dap_ch_update_core(upd),
    .dap_ch_tdi_core(tdi), .dap_ch_tdo_core(tdo),
    .reg_req(req), .reg_we(we), .reg_addr(addr), .reg_wdata(wdata),
    .reg_ack(ack), .reg_rdata(rdata), .reg_err(rerr), .busy(bsy)
  );

  // Model: chain as a bit queue (element 0 is next out on TDO) plus transaction state.
  bit            q[$];
  bit            m_busy, m_we, m_err, m_ovr;
  bit [IW-1:0]   m_addr;
  bit [DW-1:0]   m_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q = {};
    repeat (DW + 2) q.push_back(1'b0);
    m_busy = 0; m_we = 0; m_err = 0; m_ovr = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic m_capture();
    q = {};
    q.push_back(1'b1);
    q.push_back(m_err);
    repeat (DW) q.push_back(1'b0);
  endtask

  task automatic m_shift(input bit b);
    void'(q.pop_front());
    q.push_back(b);
  endtask

  // One clock of the chain rules, using the inputs sampled at the edge.
  task automatic m_step(input bit s, c, h, u, t, input bit [IW-1:0] i,
                        input bit a, input bit [DW-1:0] rd, input bit e);
    bit ec, eu, eh, ea;
    ec = s & c;
    eu = s & u & !c;
    eh = s & h & !c & !u;
    ea = a & m_busy;
    if (!m_busy) begin
      if (ec) begin
        m_capture(); m_addr = i; m_we = 0; m_ovr = 0; m_busy = 1;
      end else if (eu) begin
        if (q[1]) m_err = 0;
        else begin
          for (int k = 0; k < DW; k++) m_wdata[k] = q[k+2];
          m_addr = i; m_we = 1; m_busy = 1;
        end
      end else if (eh) m_shift(t);
    end else begin
      if (ea) begin
        if (!m_we) begin
          if (!m_ovr) begin
            q = {};
            q.push_back(1'b0);
            q.push_back(m_err | e);
            for (int k = 0; k < DW; k++) q.push_back(rd[k]);
          end
          m_err = m_err | e | m_ovr;
        end else m_err = m_err | e;
        m_busy = 0;
      end
      if (ec) m_capture();
      else if (eu) m_err = 1;
      else if (eh) begin
        m_shift(t);
        if (!m_we) m_ovr = 1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("tdo",   tdo,   sel ? q[0] : 1'b0);
    chk("req",   req,   m_busy);
    chk("busy",  bsy,   m_busy);
    chk("we",    we,    m_we);
    chk("addr",  addr,  m_addr);
    chk("wdata", wdata, m_wdata);
  endtask

  // Apply one cycle of inputs (called at negedge), update model at posedge, check at negedge.
  task automatic cyc(input logic s, c, h, u, t, input logic [IW-1:0] i,
                     input logic a, input logic [DW-1:0] rd, input logic e);
    sel = s; cap = c; shf = h; upd = u; tdi = t; id = i; ack = a; rdata = rd; rerr = e;
    @(posedge clk);
    m_step(s, c, h, u, t, i, a, rd, e);
    @(negedge clk);
    cap = 0; shf = 0; upd = 0; ack = 0; rerr = 0;
    cmp_all();
  endtask

  task automatic idle1();               cyc(1, 0, 0, 0, 0, id, 0, '0, 0); endtask
  task automatic capt(input logic [IW-1:0] i); cyc(1, 1, 0, 0, 0, i, 0, '0, 0); endtask
  task automatic shift1(input logic b); cyc(1, 0, 1, 0, b, id, 0, '0, 0); endtask
  task automatic updt(input logic [IW-1:0] i); cyc(1, 0, 0, 1, 0, i, 0, '0, 0); endtask
  task automatic acknow(input logic [DW-1:0] rd, input logic e); cyc(1, 0, 0, 0, 0, id, 1, rd, e); endtask

  typedef struct {
    logic sel, cap, shf, upd, tdi;
    logic [IW-1:0] id;
    logic ack;
    logic [DW-1:0] rd;
    logic er;
    logic e_req, e_we;
    logic [IW-1:0] e_addr;
    logic e_tdo;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic [DW+1:0] expv;
    logic          r_pend;
    int            lat;
    int            r;
    logic          c, h, u, a;

    // Read with 3-cycle request, then deselected strobes that must be ignored.
    tv[0] = '{1, 1, 0, 0, 0, 2'd2, 0, 32'h0,         0, 1, 0, 2'd2, 1};
    tv[1] = '{1, 0, 0, 0, 0, 2'd2, 0, 32'h0,         0, 1, 0, 2'd2, 1};
    tv[2] = '{1, 0, 0, 0, 0, 2'd2, 0, 32'h0,         0, 1, 0, 2'd2, 1};
    tv[3] = '{1, 0, 0, 0, 0, 2'd2, 1, 32'hA5A5_0001, 0, 0, 0, 2'd2, 0};
    tv[4] = '{0, 1, 0, 0, 0, 2'd3, 0, 32'h0,         0, 0, 0, 2'd2, 0};
    tv[5] = '{0, 0, 0, 1, 0, 2'd3, 0, 32'h0,         0, 0, 0, 2'd2, 0};
    tv[6] = '{0, 0, 1, 0, 1, 2'd3, 0, 32'h0,         0, 0, 0, 2'd2, 0};
    tv[7] = '{1, 0, 0, 0, 0, 2'd2, 0, 32'h0,         0, 0, 0, 2'd2, 0};

    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_addr", addr, 0);
    rst_n = 1;
    @(negedge clk);
    cmp_all();

    for (int k = 0; k < 8; k++) begin
      cyc(tv[k].sel, tv[k].cap, tv[k].shf, tv[k].upd, tv[k].tdi, tv[k].id,
          tv[k].ack, tv[k].rd, tv[k].er);
      chk($sformatf("tv%0d_req", k),  req,  tv[k].e_req);
      chk($sformatf("tv%0d_we", k),   we,   tv[k].e_we);
      chk($sformatf("tv%0d_addr", k), addr, tv[k].e_addr);
      chk($sformatf("tv%0d_tdo", k),  tdo,  tv[k].e_tdo);
    end

    // Read-back: 0, 0, then data LSB first.
    expv = {32'hA5A5_0001, 2'b00};
    for (int k = 0; k < DW + 2; k++) begin
      chk($sformatf("rd_tdo%0d", k), tdo, expv[k]);
      shift1(1'b0);
    end

    // Write: shift {data,0,0} LSB first, then update.
    expv = {32'h1234_5678, 2'b00};
    id = 2'd1;
    for (int k = 0; k < DW + 2; k++) shift1(expv[k]);
    updt(2'd1);
    chk("wr_req", req, 1);
    chk("wr_we", we, 1);
    chk("wr_addr", addr, 1);
    chk("wr_wdata", wdata, 32'h1234_5678);
    acknow('0, 0);
    chk("wr_req_drop", req, 0);

    // Overrun: shift during read, data discarded, sticky error visible on next capture.
    capt(2'd0);
    shift1(1'b1);
    acknow(32'hFFFF_FFFF, 0);
    chk("ovr_tdo0", tdo, 0);
    capt(2'd0);
    chk("ovr_cap_busy", tdo, 1);
    shift1(1'b0);
    chk("ovr_cap_err", tdo, 1);
    acknow(32'h0, 0);

    // Collision: update while reading is dropped; then clear command in IDLE.
    capt(2'd3);
    updt(2'd3);
    chk("col_req", req, 1);
    chk("col_we", we, 0);
    acknow(32'h0000_00F0, 0);
    idle1();
    chk("col_noreq", req, 0);
    updt(2'd2);
    chk("clr_noreq", req, 0);
    capt(2'd2);
    shift1(1'b0);
    chk("clr_err", tdo, 0);
    acknow('0, 0);

    // Reset while a request is outstanding.
    capt(2'd1);
    chk("rst_pre_req", req, 1);
    #2 rst_n = 0;
    #1;
    chk("rstmid_req", req, 0);
    chk("rstmid_busy", bsy, 0);
    chk("rstmid_tdo", tdo, 0);
    chk("rstmid_addr", addr, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    idle1();
    idle1();

    // Random traffic with a latency-randomised responder and stray acks.
    r_pend = 0; lat = 0;
    for (int n = 0; n < 3000; n++) begin
      a = 0;
      if (m_busy) begin
        if (!r_pend) begin r_pend = 1; lat = $urandom_range(0, 3); end
        if (lat == 0) begin a = 1; r_pend = 0; end
        else lat--;
      end else if ($urandom_range(0, 19) == 0) a = 1;
      r = $urandom_range(0, 15);
      c = (r < 3) || (r == 12);
      h = (r >= 3 && r < 9) || (r == 12) || (r == 13);
      u = (r == 9 || r == 10 || r == 12 || r == 13);
      if (a && m_busy) begin c = 0; h = 0; end
      cyc($urandom_range(0, 9) != 0, c, h, u, 1'($urandom), 2'($urandom),
          a, $urandom, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
